powlib_syncfifo: RTL

Single-clock, parametrised FIFO with valid/ready handshakes on both sides, first-word-fall-through read, occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It is the standard buffering element between powlib pipeline stages. It replaces ad-hoc `powlib_pipe` chains wherever backpressure or elastic depth is required.

---
 rtl/powlib_syncfifo_pkg.sv | 36 +++
 rtl/powlib_syncfifo_dpram.sv | 31 +++
 rtl/powlib_syncfifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/powlib_syncfifo_pkg.sv
// Shared constants and helper functions for the powlib synchronous FIFO.
package powlib_syncfifo_pkg;

    // Legal depth range for the FIFO storage array.
    localparam int D_MIN = 2;
    localparam int D_MAX = 65536;

    // Ceiling log2, with a minimum of 1 so a 2-entry array still gets an index bit.
    function automatic int powlib_clogb2(input int value);
        int          res;
        int unsigned v;
        res = 0;
        v   = int'(value) - 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v != 0) begin
                res = res + 1;
                v   = v >> 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

    // Binary-to-Gray conversion.
    function automatic logic [31:0] powlib_grayencode(input logic [31:0] value);
        return value ^ (value >> 1);
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit powlib_ispow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/powlib_syncfifo_dpram.sv
// D x W storage array: one synchronous write port, one combinational read port.
module powlib_syncfifo_dpram
    import powlib_syncfifo_pkg::*;
#(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int WIDX = powlib_clogb2(D)
) (
    input  logic            clk,
    input  logic            wren,
    input  logic [WIDX-1:0] wridx,
    input  logic [W-1:0]    wrdata,
    input  logic [WIDX-1:0] rdidx,
    output logic [W-1:0]    rddata
);

    logic [W-1:0] mem [D];

    // Store the accepted word; contents are never reset or flushed.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wridx] <= wrdata;
        end
    end

    // First-word-fall-through: read data follows the read index directly.
    always_comb begin
        rddata = mem[rdidx];
    end

endmodule

// File: rtl/powlib_syncfifo.sv
// Single-clock FIFO with valid/ready on both sides, FWFT read, occupancy
// count, almost-full/almost-empty flags and a synchronous flush.
module powlib_syncfifo
    import powlib_syncfifo_pkg::*;
#(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int WIDX = powlib_clogb2(D),
    parameter int AFT  = D - 2,
    parameter int AET  = 1,
    parameter int EDBG = 0,
    parameter     ID   = "SYNCFIFO"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  wrdata,
    input  logic          wrvld,
    output logic          wrrdy,
    output logic [W-1:0]  rddata,
    output logic          rdvld,
    input  logic          rdrdy,
    output logic [WIDX:0] cnt,
    output logic          afull,
    output logic          aempty
);

    localparam bit PARAM_OK = powlib_ispow2(D) && (D >= D_MIN) && (D <= D_MAX)
                              && (AFT <= D) && (AET < D);

    // Parameter sanity check, only when debugging is enabled.
    if ((EDBG != 0) && (ID != '0)) begin : g_dbg
        if (!PARAM_OK) begin : g_bad
            $fatal(1, "powlib_syncfifo: illegal parameters (D must be a power of 2 in range, AFT<=D, AET<D)");
        end
    end

    logic [WIDX:0] wrptr, rdptr;
    logic [WIDX:0] wrptr_next, rdptr_next;
    logic [WIDX:0] cnt_next;
    logic          wr_acc, rd_acc;
    logic          empty_next, full_next;

    // Handshake acceptance; flush suppresses both transfers.
    always_comb begin
        wr_acc = wrvld && wrrdy && !clr;
        rd_acc = rdvld && rdrdy && !clr;
    end

    // Next pointer / count values and the flags derived from them.
    always_comb begin
        wrptr_next = wrptr;
        rdptr_next = rdptr;
        cnt_next   = cnt;
        if (clr) begin
            wrptr_next = '0;
            rdptr_next = '0;
            cnt_next   = '0;
        end else begin
            wrptr_next = wrptr + (WIDX+1)'(wr_acc);
            rdptr_next = rdptr + (WIDX+1)'(rd_acc);
            cnt_next   = cnt + (WIDX+1)'(wr_acc) - (WIDX+1)'(rd_acc);
        end
        empty_next = (wrptr_next == rdptr_next);
        full_next  = (wrptr_next[WIDX] != rdptr_next[WIDX]) &&
                     (wrptr_next[WIDX-1:0] == rdptr_next[WIDX-1:0]);
    end

    // Pointer registers; the MSB is the wrap bit so full and empty differ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            wrptr <= wrptr_next;
            rdptr <= rdptr_next;
        end
    end

    // Count, handshake and flag registers, all loaded from the same next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            wrrdy  <= 1'b0;
            rdvld  <= 1'b0;
            afull  <= (AFT == 0);
            aempty <= 1'b1;
        end else begin
            cnt    <= cnt_next;
            wrrdy  <= !full_next;
            rdvld  <= !empty_next;
            afull  <= (cnt_next >= (WIDX+1)'(AFT));
            aempty <= (cnt_next <= (WIDX+1)'(AET));
        end
    end

    powlib_syncfifo_dpram #(
        .W    (W),
        .D    (D),
        .WIDX (WIDX)
    ) u_mem (
        .clk    (clk),
        .wren   (wr_acc),
        .wridx  (wrptr[WIDX-1:0]),
        .wrdata (wrdata),
        .rdidx  (rdptr[WIDX-1:0]),
        .rddata (rddata)
    );

endmodule
